// File: rtl/onewire_master_bit_if.sv
// Command/response handshake between the byte sequencer and the 1-wire bit engine.
// The sequencer uses the master modport; the engine uses the slave modport.
interface onewire_master_bit_if;
  logic cmd_vld;
  logic cmd_rdy;
  logic cmd_rst;
  logic cmd_dat;
  logic cmd_ovd;
  logic rsp_vld;
  logic rsp_dat;

  modport master (
    output cmd_vld, cmd_rst, cmd_dat, cmd_ovd,
    input  cmd_rdy, rsp_vld, rsp_dat
  );

  modport slave (
    input  cmd_vld, cmd_rst, cmd_dat, cmd_ovd,
    output cmd_rdy, rsp_vld, rsp_dat
  );
endinterface

// File: rtl/onewire_master_bit.sv
// Open-loop 1-wire bit engine: runs one reset/presence cycle or one bit slot per command,
// timed in ticks of CDR clocks, and returns one sampled result bit.
module onewire_master_bit #(
  parameter logic [15:0] CDR_N = 16'd375,
  parameter logic [15:0] CDR_O = 16'd50,
  parameter int          CDW   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  onewire_master_bit_if.slave   bus,
  output logic                  owr_p,
  input  logic                  owr_i
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BIT  = 2'd1;
  localparam logic [1:0] RST  = 2'd2;

  localparam logic [CDW-1:0] LAST_N = CDW'(CDR_N - 16'd1);
  localparam logic [CDW-1:0] LAST_O = CDW'(CDR_O - 16'd1);

  logic [1:0]     state;
  logic [CDW-1:0] div;
  logic [CDW-1:0] div_last;
  logic [6:0]     tcnt;
  logic [6:0]     tnext;
  logic           dat_q;
  logic           smp;
  logic           owr_m;
  logic           owr_s;
  logic           rsp_vld_q;
  logic           rsp_dat_q;
  logic           tick;
  logic           last_t;
  logic           pull_next;

  assign tick  = (state != IDLE) && (div == div_last);
  assign tnext = tcnt + 7'd1;

  // Pull level for the tick that begins after the current tick ends.
  always_comb begin
    last_t    = 1'b0;
    pull_next = 1'b0;
    case (state)
      BIT: begin
        last_t    = (tcnt == 7'd7);
        pull_next = !dat_q && (tnext <= 7'd6);
      end
      RST: begin
        last_t    = (tcnt == 7'd127);
        pull_next = (tnext < 7'd64);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      div_last  <= '0;
      tcnt      <= '0;
      dat_q     <= 1'b0;
      smp       <= 1'b0;
      owr_m     <= 1'b1;
      owr_s     <= 1'b1;
      rsp_vld_q <= 1'b0;
      rsp_dat_q <= 1'b0;
      owr_p     <= 1'b0;
    end else begin
      owr_m     <= owr_i;
      owr_s     <= owr_m;
      rsp_vld_q <= 1'b0;
      if (state == IDLE) begin
        if (bus.cmd_vld) begin
          state    <= bus.cmd_rst ? RST : BIT;
          div      <= '0;
          tcnt     <= '0;
          div_last <= bus.cmd_ovd ? LAST_O : LAST_N;
          dat_q    <= bus.cmd_dat;
          owr_p    <= 1'b1;
        end
      end else if (tick) begin
        div  <= '0;
        tcnt <= tnext;
        if (state == BIT && tcnt == 7'd1)
          smp <= owr_s;
        // A slave pulling low at this point signals presence.
        if (state == RST && tcnt == 7'd72)
          smp <= ~owr_s;
        if (last_t) begin
          state     <= IDLE;
          tcnt      <= '0;
          rsp_vld_q <= 1'b1;
          rsp_dat_q <= smp;
          owr_p     <= 1'b0;
        end else begin
          owr_p <= pull_next;
        end
      end else begin
        div <= div + CDW'(1);
      end
    end
  end

  assign bus.cmd_rdy = (state == IDLE);
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_dat = rsp_dat_q;

endmodule

// File: tb/tb_onewire_master_bit.sv
// Randomized bench for onewire_master_bit with a pull-up, a presence/read slave model,
// and a slot-level timing/result reference model.
module tb_onewire_master_bit;
  logic clk = 1'b0;
  logic rst;
  logic owr_p;
  logic owr_i;

  onewire_master_bit_if bus();

  onewire_master_bit #(.CDR_N(16'd4), .CDR_O(16'd2), .CDW(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .owr_p (owr_p),
    .owr_i (owr_i)
  );

  always #5 clk = ~clk;

  // Slave: answers a long low pulse with presence; when rd_bit=0 it holds the bus
  // low for 10 clocks after any master pull starts.
  bit   slave_present;
  bit   rd_bit;
  int   sc = 10000, plen = 0, lastlen = 0, rc = 10000;
  logic owr_p_d = 1'b0;
  logic slave_pull;

  always @(posedge clk) begin
    owr_p_d <= owr_p;
    if (owr_p && !owr_p_d) begin
      sc   <= 0;
      plen <= 1;
    end else begin
      if (sc < 10000) sc <= sc + 1;
      if (owr_p) plen <= plen + 1;
    end
    if (!owr_p && owr_p_d) begin
      lastlen <= plen;
      rc      <= 0;
    end else if (rc < 10000) begin
      rc <= rc + 1;
    end
  end

  assign slave_pull = (!rd_bit && sc < 10) ||
                      (slave_present && lastlen >= 100 && rc >= 4 && rc < 60);
  assign owr_i = ~(owr_p | slave_pull);

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Slot-level reference: pull length, response cycle (1 = first cycle after accept), result.
  function automatic void model(input bit r, input bit d, input bit o, input bit pres,
                                input bit rb, output int high, output int rspc,
                                output bit dat);
    int cdr;
    int ticks;
    cdr   = o ? 2 : 4;
    ticks = r ? 128 : 8;
    high  = (r ? 64 : (d ? 1 : 7)) * cdr;
    rspc  = ticks * cdr + 1;
    if (r)
      dat = pres;
    else if (!d)
      dat = 1'b0;
    else
      // In overdrive the synchronised bus seen at the sample point is still inside the master pull.
      dat = o ? 1'b0 : rb;
  endfunction

  task automatic send(input bit r, input bit d, input bit o, output int waits);
    bus.cmd_vld = 1'b1;
    bus.cmd_rst = r;
    bus.cmd_dat = d;
    bus.cmd_ovd = o;
    waits = 0;
    while (bus.cmd_rdy !== 1'b1 && waits < 1000) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 1000) chk("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_vld = 1'b0;
  endtask

  task automatic measure(input bit r, input bit d, input bit o, input bit poke,
                         input bit exp_dat, input int exp_high, input int exp_rsp);
    int high  = 0;
    int first = 0;
    int lasth = 0;
    int rspc  = 0;
    chk("rdy_busy", bus.cmd_rdy, 0);
    for (int n = 1; n <= 700 && rspc == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (owr_p === 1'b1) begin
        high++;
        if (first == 0) first = n;
        lasth = n;
      end
      if (poke && n == 3) begin
        bus.cmd_vld = 1'b1;
        bus.cmd_rst = ~r;
        bus.cmd_dat = ~d;
        bus.cmd_ovd = ~o;
        chk("rdy_poke", bus.cmd_rdy, 0);
      end
      if (poke && n == 6) bus.cmd_vld = 1'b0;
      if (bus.rsp_vld === 1'b1) rspc = n;
    end
    chk("pull_start",  first, 1);
    chk("pull_len",    high, exp_high);
    chk("pull_contig", lasth, exp_high);
    chk("rsp_cycle",   rspc, exp_rsp);
    chk("rsp_dat",     bus.rsp_dat, exp_dat);
    chk("rdy_at_rsp",  bus.cmd_rdy, 1);
  endtask

  task automatic run_one(input bit r, input bit d, input bit o, input bit pres, input bit rb,
                         input bit poke, input bit b2b, input bit chk_b2b);
    int  eh, er, w;
    bit  ed;
    model(r, d, o, pres, rb, eh, er, ed);
    slave_present = pres;
    rd_bit        = rb;
    send(r, d, o, w);
    if (chk_b2b) chk("b2b_accept_wait", w, 0);
    measure(r, d, o, poke, ed, eh, er);
    if (!b2b) begin
      @(negedge clk);
      chk("rsp_pulse", bus.rsp_vld, 0);
      chk("rsp_hold",  bus.rsp_dat, ed);
      repeat (2) @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int w;
    int rsp_seen;
    rst           = 1'b1;
    bus.cmd_vld   = 1'b0;
    bus.cmd_rst   = 1'b0;
    bus.cmd_dat   = 1'b0;
    bus.cmd_ovd   = 1'b0;
    slave_present = 1'b1;
    rd_bit        = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_owr_p",   owr_p, 0);
    chk("rst_cmd_rdy", bus.cmd_rdy, 1);
    chk("rst_rsp_vld", bus.rsp_vld, 0);
    chk("rst_rsp_dat", bus.rsp_dat, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Directed: presence, no presence, write-0, back-to-back reads, overdrive, busy poke.
    run_one(1, 0, 0, 1, 1, 0, 0, 0);
    run_one(1, 0, 0, 0, 1, 0, 0, 0);
    run_one(0, 0, 0, 1, 1, 0, 0, 0);
    run_one(0, 1, 0, 1, 0, 0, 1, 0);
    run_one(0, 1, 0, 1, 1, 0, 0, 1);
    run_one(0, 0, 1, 1, 1, 0, 0, 0);
    run_one(1, 0, 1, 1, 1, 0, 0, 0);
    run_one(0, 1, 0, 1, 1, 1, 0, 0);

    // Reset in the middle of a reset cycle, at the start of tick 30.
    slave_present = 1'b1;
    rd_bit        = 1'b1;
    send(1, 0, 0, w);
    repeat (120) @(negedge clk);
    chk("midrst_pull_before", owr_p, 1);
    rst = 1'b1;
    #1;
    chk("midrst_owr_p",   owr_p, 0);
    chk("midrst_cmd_rdy", bus.cmd_rdy, 1);
    rsp_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rsp_vld === 1'b1) rsp_seen++;
    end
    rst = 1'b0;
    repeat (400) begin
      @(negedge clk);
      if (bus.rsp_vld === 1'b1) rsp_seen++;
    end
    chk("midrst_no_rsp", rsp_seen, 0);
    run_one(0, 0, 0, 1, 1, 0, 0, 0);
    run_one(1, 0, 0, 1, 1, 0, 0, 0);

    // Random commands against the slot-level model.
    for (int i = 0; i < 24; i++) begin
      bit r, d, o, p, rb, pk;
      r  = ($urandom_range(0, 3) == 0);
      d  = $urandom_range(0, 1);
      o  = $urandom_range(0, 1);
      p  = $urandom_range(0, 1);
      rb = $urandom_range(0, 1);
      pk = ($urandom_range(0, 3) == 0);
      run_one(r, d, o, p, rb, pk, 0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
